// File: rtl/zafx32_pkg.sv
// Shared ZAFx32 control encodings: opcodes, FSM states, and datapath mux selects.
// Imported by the control FSM and by the datapath muxes that consume its selects.
package zafx32_pkg;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIS = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] EXT_SEL_11 = 2'd0;
   localparam logic [1:0] EXT_SEL_16 = 2'd1;
   localparam logic [1:0] EXT_SEL_26 = 2'd2;

   localparam logic [2:0] ALU_OP_ADD   = 3'd0;
   localparam logic [2:0] ALU_OP_SUB   = 3'd1;
   localparam logic [2:0] ALU_OP_FUNCT = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_W,
      ST_DECODE,
      ST_EXEC,
      ST_MEM_W,
      ST_WB,
      ST_HALT,
      ST_FAULT
   } state_e;

   typedef enum logic [3:0] {
      CLS_R,
      CLS_ADDI,
      CLS_ADDIS,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_J,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_e;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic [1:0] ext_sel;
      logic [2:0] alu_op;
      logic       alu_srcb;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic       wb_sel;
      logic       halted;
      logic       fault;
   } ctrl_t;

   function automatic op_class_e decode_class(input logic [5:0] op);
      op_class_e cls;
      cls = CLS_ILLEGAL;
      case (op)
         OP_R:     cls = CLS_R;
         OP_J:     cls = CLS_J;
         OP_BEQ:   cls = CLS_BEQ;
         OP_ADDI:  cls = CLS_ADDI;
         OP_ADDIS: cls = CLS_ADDIS;
         OP_LW:    cls = CLS_LW;
         OP_SW:    cls = CLS_SW;
         OP_HALT:  cls = CLS_HALT;
         default:  cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   // Classes without an immediate report ext11 so the select never floats.
   function automatic logic [1:0] ext_sel_of(input op_class_e cls);
      logic [1:0] sel;
      sel = EXT_SEL_11;
      case (cls)
         CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ: sel = EXT_SEL_16;
         CLS_J:                             sel = EXT_SEL_26;
         default:                           sel = EXT_SEL_11;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/zafx32_multicycle_ctrl_if.sv
// Unified memory port handshake between the control FSM (master) and memory (slave).
interface zafx32_multicycle_ctrl_if;

   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      output mem_ready
   );

endinterface

// File: rtl/zafx32_mem_watchdog.sv
// Saturating wait counter for stalled memory accesses; flags the cycle in which
// the count would reach MEM_TIMEOUT.
module zafx32_mem_watchdog #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // NOTE: count_d gets a default before any branch so always_comb can never infer a latch.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != LIMIT)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is flagged on the stalled cycle that would make the count reach the limit.
   assign expire_o = inc_i && (count_q >= LAST);

endmodule

// File: rtl/zafx32_multicycle_ctrl.sv
// Multi-cycle control FSM for the ZAFx32 core: fetch/decode/execute/memory/writeback
// sequencing, immediate-extender select, and a watchdog-guarded memory handshake.
module zafx32_multicycle_ctrl
   import zafx32_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic                             clk,
   input  logic                             rst,
   zafx32_multicycle_ctrl_if.master         mem_if,
   input  logic [5:0]                       opcode_i,
   input  logic                             zero_i,
   output logic                             pc_write_o,
   output logic [1:0]                       pc_src_o,
   output logic                             ir_write_o,
   output logic [1:0]                       ext_sel_o,
   output logic [2:0]                       alu_op_o,
   output logic                             alu_srcb_o,
   output logic                             reg_write_o,
   output logic                             wb_sel_o,
   output logic                             halted_o,
   output logic                             fault_o
);

   state_e    state_q;
   state_e    state_d;
   op_class_e class_q;
   op_class_e class_d;
   ctrl_t     ctrl;

   logic wait_st;
   logic wd_clr;
   logic wd_inc;
   logic wd_expire;

   // Counter restarts whenever we are outside a wait state or an access completes,
   // so every FETCH_W/MEM_W entry (including MEM_W -> FETCH_W) begins at zero.
   assign wait_st = (state_q == ST_FETCH_W) || (state_q == ST_MEM_W);
   assign wd_clr  = !wait_st || mem_if.mem_ready;
   assign wd_inc  = wait_st && !mem_if.mem_ready;

   zafx32_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr),
      .inc_i    (wd_inc),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         class_q <= CLS_R;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
      end
   end

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH_W;

         // Completion takes priority over an expiry flagged in the same cycle.
         ST_FETCH_W: begin
            if (mem_if.mem_ready) begin
               state_d = ST_DECODE;
            end else if (wd_expire) begin
               state_d = ST_FAULT;
            end
         end

         ST_DECODE: begin
            class_d = decode_class(opcode_i);
            case (class_d)
               CLS_HALT:    state_d = ST_HALT;
               CLS_ILLEGAL: state_d = ST_FAULT;
               default:     state_d = ST_EXEC;
            endcase
         end

         ST_EXEC: begin
            case (class_q)
               CLS_LW, CLS_SW:  state_d = ST_MEM_W;
               CLS_BEQ, CLS_J:  state_d = ST_FETCH_W;
               default:         state_d = ST_WB;
            endcase
         end

         ST_MEM_W: begin
            if (mem_if.mem_ready) begin
               state_d = (class_q == CLS_SW) ? ST_FETCH_W : ST_WB;
            end else if (wd_expire) begin
               state_d = ST_FAULT;
            end
         end

         ST_WB: state_d = ST_FETCH_W;

         default: state_d = state_q;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         // IR and PC load only on the completion beat, so a stalled fetch never advances the PC.
         ST_FETCH_W: begin
            ctrl.mem_req  = 1'b1;
            ctrl.ir_write = mem_if.mem_ready;
            ctrl.pc_write = mem_if.mem_ready;
            ctrl.pc_src   = PC_SRC_SEQ;
         end

         ST_DECODE: ctrl.ext_sel = ext_sel_of(decode_class(opcode_i));

         ST_EXEC: begin
            ctrl.ext_sel = ext_sel_of(class_q);
            case (class_q)
               CLS_R: ctrl.alu_op = ALU_OP_FUNCT;
               CLS_ADDI, CLS_ADDIS, CLS_LW, CLS_SW: begin
                  ctrl.alu_op   = ALU_OP_ADD;
                  ctrl.alu_srcb = 1'b1;
               end
               CLS_BEQ: begin
                  ctrl.alu_op   = ALU_OP_SUB;
                  ctrl.pc_write = zero_i;
                  ctrl.pc_src   = PC_SRC_BRANCH;
               end
               CLS_J: begin
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PC_SRC_JUMP;
               end
               default: ctrl.alu_op = ALU_OP_ADD;
            endcase
         end

         ST_MEM_W: begin
            ctrl.ext_sel = ext_sel_of(class_q);
            ctrl.mem_req = 1'b1;
            ctrl.mem_we  = (class_q == CLS_SW);
         end

         ST_WB: begin
            ctrl.ext_sel   = ext_sel_of(class_q);
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = (class_q == CLS_LW);
         end

         ST_HALT:  ctrl.halted = 1'b1;
         ST_FAULT: ctrl.fault  = 1'b1;
         default:  ctrl.fault  = 1'b0;
      endcase
   end

   assign mem_if.mem_req = ctrl.mem_req;
   assign mem_if.mem_we  = ctrl.mem_we;
   assign pc_write_o     = ctrl.pc_write;
   assign pc_src_o       = ctrl.pc_src;
   assign ir_write_o     = ctrl.ir_write;
   assign ext_sel_o      = ctrl.ext_sel;
   assign alu_op_o       = ctrl.alu_op;
   assign alu_srcb_o     = ctrl.alu_srcb;
   assign reg_write_o    = ctrl.reg_write;
   assign wb_sel_o       = ctrl.wb_sel;
   assign halted_o       = ctrl.halted;
   assign fault_o        = ctrl.fault;

endmodule

// File: tb/tb_zafx32_multicycle_ctrl.sv
// Directed bench for zafx32_multicycle_ctrl; outputs are packed as
// {pc_write, pc_src[1:0], ir_write, ext_sel[1:0], alu_op[2:0], alu_srcb, mem_req, mem_we, reg_write, wb_sel, halted, fault}.
module tb_zafx32_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   int         n_total = 0;
   int         n_pass  = 0;
   logic [15:0] exp;

   always #5 clk = ~clk;

   zafx32_multicycle_ctrl_if if_a ();
   zafx32_multicycle_ctrl_if if_b ();

   logic       a_pc_write, a_ir_write, a_alu_srcb, a_reg_write, a_wb_sel, a_halted, a_fault;
   logic [1:0] a_pc_src, a_ext_sel;
   logic [2:0] a_alu_op;
   logic       b_pc_write, b_ir_write, b_alu_srcb, b_reg_write, b_wb_sel, b_halted, b_fault;
   logic [1:0] b_pc_src, b_ext_sel;
   logic [2:0] b_alu_op;
   logic [15:0] a_ctrl, b_ctrl;

   assign a_ctrl = {a_pc_write, a_pc_src, a_ir_write, a_ext_sel, a_alu_op, a_alu_srcb,
                    if_a.mem_req, if_a.mem_we, a_reg_write, a_wb_sel, a_halted, a_fault};
   assign b_ctrl = {b_pc_write, b_pc_src, b_ir_write, b_ext_sel, b_alu_op, b_alu_srcb,
                    if_b.mem_req, if_b.mem_we, b_reg_write, b_wb_sel, b_halted, b_fault};

   zafx32_multicycle_ctrl u_dut (
      .clk(clk), .rst(rst), .mem_if(if_a), .opcode_i(opcode), .zero_i(zero),
      .pc_write_o(a_pc_write), .pc_src_o(a_pc_src), .ir_write_o(a_ir_write),
      .ext_sel_o(a_ext_sel), .alu_op_o(a_alu_op), .alu_srcb_o(a_alu_srcb),
      .reg_write_o(a_reg_write), .wb_sel_o(a_wb_sel), .halted_o(a_halted), .fault_o(a_fault)
   );

   zafx32_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut_to (
      .clk(clk), .rst(rst), .mem_if(if_b), .opcode_i(opcode), .zero_i(zero),
      .pc_write_o(b_pc_write), .pc_src_o(b_pc_src), .ir_write_o(b_ir_write),
      .ext_sel_o(b_ext_sel), .alu_op_o(b_alu_op), .alu_srcb_o(b_alu_srcb),
      .reg_write_o(b_reg_write), .wb_sel_o(b_wb_sel), .halted_o(b_halted), .fault_o(b_fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_a.mem_ready = 1'b0;
      if_b.mem_ready = 1'b0;
      opcode = 6'h00;
      zero = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Runs DUT A through FETCH_W (entered already); ready arrives on wait cycle 'delay'.
   task automatic fetch_op(input string tag, input logic [5:0] op, input int delay);
      for (int i = 0; i <= delay; i++) begin
         if_a.mem_ready = (i == delay);
         #1;
         exp = (i == delay) ? 16'h9020 : 16'h0020;
         n_total++;
         if (a_ctrl !== exp) $display("FAIL %s_fetch%0d: ctrl=%h expected %h", tag, i, a_ctrl, exp);
         else n_pass++;
         tick();
      end
      if_a.mem_ready = 1'b0;
      opcode = op;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      opcode = 6'h00;
      zero = 1'b0;
      if_a.mem_ready = 1'b0;
      if_b.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({a_ctrl, b_ctrl} !== 32'h0) $display("FAIL reset_hold: a=%h b=%h expected 0000 0000", a_ctrl, b_ctrl);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if (a_ctrl !== 16'h0000) $display("FAIL reset_idle: ctrl=%h expected 0000", a_ctrl);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'h0020) $display("FAIL reset_fetch: ctrl=%h expected 0020", a_ctrl);
      else n_pass++;
   endtask

   // Request cycle is cycle 0; WB (the reg_write pulse) is the fifth cycle, index 4.
   task automatic test_addis();
      logic [15:0] tab [4] = '{16'h0000, 16'h0040, 16'h0008, 16'h0020};
      int rw_count = 0;
      int rw_cycle = -1;
      fetch_op("addis", 6'h09, 1);
      for (int c = 2; c <= 5; c++) begin
         #1;
         if (a_reg_write === 1'b1) begin
            rw_count++;
            rw_cycle = c;
         end
         n_total++;
         if (a_ctrl !== tab[c-2]) $display("FAIL addis_cyc%0d: ctrl=%h expected %h", c, a_ctrl, tab[c-2]);
         else n_pass++;
         tick();
      end
      n_total++;
      if (rw_count != 1 || rw_cycle != 4)
         $display("FAIL addis_regwrite: pulses=%0d at cycle %0d expected 1 at cycle 4", rw_count, rw_cycle);
      else n_pass++;
   endtask

   task automatic test_alu_ops();
      logic [5:0]  ops [2] = '{6'h00, 6'h08};
      logic [15:0] tab [2][3] = '{'{16'h0000, 16'h0100, 16'h0008}, '{16'h0400, 16'h0440, 16'h0408}};
      for (int k = 0; k < 2; k++) begin
         fetch_op("alu", ops[k], 0);
         for (int s = 0; s < 3; s++) begin
            #1;
            n_total++;
            if (a_ctrl !== tab[k][s]) $display("FAIL alu_op%h_st%0d: ctrl=%h expected %h", ops[k], s, a_ctrl, tab[k][s]);
            else n_pass++;
            tick();
         end
      end
   endtask

   task automatic test_beq();
      logic z;
      for (int k = 0; k < 2; k++) begin
         z = (k == 0);
         fetch_op("beq", 6'h04, 0);
         #1;
         n_total++;
         if (a_ctrl !== 16'h0400) $display("FAIL beq_decode: ctrl=%h expected 0400", a_ctrl);
         else n_pass++;
         tick();
         zero = z;
         #1;
         exp = z ? 16'hA480 : 16'h2480;
         n_total++;
         if (a_ctrl !== exp) $display("FAIL beq_exec_zero%0b: ctrl=%h expected %h", z, a_ctrl, exp);
         else n_pass++;
         tick();
         zero = 1'b0;
      end
   endtask

   task automatic test_jump();
      fetch_op("j", 6'h02, 0);
      #1;
      n_total++;
      if (a_ctrl !== 16'h0800) $display("FAIL j_decode: ctrl=%h expected 0800", a_ctrl);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'hC800) $display("FAIL j_exec: ctrl=%h expected C800", a_ctrl);
      else n_pass++;
      tick();
   endtask

   task automatic test_lw_slow();
      int req_cycles = 0;
      fetch_op("lw", 6'h23, 2);
      #1;
      n_total++;
      if (a_ctrl !== 16'h0400) $display("FAIL lw_decode: ctrl=%h expected 0400", a_ctrl);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'h0440) $display("FAIL lw_exec: ctrl=%h expected 0440", a_ctrl);
      else n_pass++;
      tick();
      for (int i = 0; i <= 10; i++) begin
         if_a.mem_ready = (i == 10);
         #1;
         if (if_a.mem_req === 1'b1) req_cycles++;
         n_total++;
         if (a_ctrl !== 16'h0420) $display("FAIL lw_mem%0d: ctrl=%h expected 0420", i, a_ctrl);
         else n_pass++;
         tick();
      end
      if_a.mem_ready = 1'b0;
      #1;
      n_total++;
      if (a_ctrl !== 16'h040C) $display("FAIL lw_wb: ctrl=%h expected 040C", a_ctrl);
      else n_pass++;
      n_total++;
      if (req_cycles != 11) $display("FAIL lw_req_len: mem_req high %0d cycles expected 11", req_cycles);
      else n_pass++;
      tick();
   endtask

   // mem_ready asserted outside a request must be ignored; SW completion re-requests at once.
   task automatic test_back_to_back();
      fetch_op("sw", 6'h2B, 0);
      if_a.mem_ready = 1'b1;
      #1;
      n_total++;
      if (a_ctrl !== 16'h0400) $display("FAIL sw_decode: ctrl=%h expected 0400", a_ctrl);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'h0440) $display("FAIL sw_exec_ready_ignored: ctrl=%h expected 0440", a_ctrl);
      else n_pass++;
      tick();
      for (int i = 0; i < 2; i++) begin
         if_a.mem_ready = (i == 1);
         #1;
         n_total++;
         if (a_ctrl !== 16'h0430) $display("FAIL sw_mem%0d: ctrl=%h expected 0430", i, a_ctrl);
         else n_pass++;
         tick();
      end
      if_a.mem_ready = 1'b0;
      #1;
      n_total++;
      if (a_ctrl !== 16'h0020) $display("FAIL sw_back_to_back: ctrl=%h expected 0020", a_ctrl);
      else n_pass++;
   endtask

   task automatic test_halt();
      fetch_op("halt", 6'h3F, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if_a.mem_ready = i[0];
         #1;
         n_total++;
         if (a_ctrl !== 16'h0002) $display("FAIL halt_sticky%0d: ctrl=%h expected 0002", i, a_ctrl);
         else n_pass++;
         tick();
      end
      if_a.mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      tick();
      fetch_op("rstmid", 6'h23, 0);
      tick();
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'h0420) $display("FAIL rstmid_memw: ctrl=%h expected 0420", a_ctrl);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (a_ctrl !== 16'h0000) $display("FAIL rstmid_async: ctrl=%h expected 0000", a_ctrl);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (a_ctrl !== 16'h0000) $display("FAIL rstmid_idle: ctrl=%h expected 0000", a_ctrl);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if (a_ctrl !== 16'h0020) $display("FAIL rstmid_fetch: ctrl=%h expected 0020", a_ctrl);
      else n_pass++;
   endtask

   task automatic test_illegal();
      fetch_op("illegal", 6'h11, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (a_ctrl !== 16'h0001) $display("FAIL illegal_fault%0d: ctrl=%h expected 0001", i, a_ctrl);
         else n_pass++;
         tick();
      end
   endtask

   // DUT B has MEM_TIMEOUT=4: four stalled cycles fault, ready on the fourth completes.
   task automatic test_timeout();
      do_reset();
      tick();
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_total++;
         if (b_ctrl !== 16'h0020) $display("FAIL to_wait%0d: ctrl=%h expected 0020", i, b_ctrl);
         else n_pass++;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         if_b.mem_ready = 1'b1;
         #1;
         n_total++;
         if (b_ctrl !== 16'h0001) $display("FAIL to_fault%0d: ctrl=%h expected 0001", i, b_ctrl);
         else n_pass++;
         tick();
      end
      do_reset();
      tick();
      for (int i = 1; i <= 4; i++) begin
         if_b.mem_ready = (i == 4);
         #1;
         exp = (i == 4) ? 16'h9020 : 16'h0020;
         n_total++;
         if (b_ctrl !== exp) $display("FAIL to_edge_wait%0d: ctrl=%h expected %h", i, b_ctrl, exp);
         else n_pass++;
         tick();
      end
      if_b.mem_ready = 1'b0;
      opcode = 6'h2B;
      #1;
      n_total++;
      if (b_ctrl !== 16'h0400) $display("FAIL to_edge_decode: ctrl=%h expected 0400", b_ctrl);
      else n_pass++;
      tick();
      tick();
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_total++;
         if (b_ctrl !== 16'h0430) $display("FAIL to_memw_wait%0d: ctrl=%h expected 0430", i, b_ctrl);
         else n_pass++;
         tick();
      end
      #1;
      n_total++;
      if (b_ctrl !== 16'h0001) $display("FAIL to_memw_fault: ctrl=%h expected 0001", b_ctrl);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_addis();
      test_alu_ops();
      test_beq();
      test_jump();
      test_lw_slow();
      test_back_to_back();
      test_halt();
      test_reset_mid_mem();
      test_illegal();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL sim_time_limit: got no finish by 50000, required finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
